// File: rtl/axi4_chan_queue_bank.sv
// axi4_chan_queue_bank: NUM_CH independent ready/valid FIFOs with packed
// payloads. Each channel can be set to pipe mode (accept while full if the
// head leaves) or flow mode (combinational bypass when empty). Each channel
// also has its own flush and a registered occupancy count.
module axi4_chan_queue_bank #(
  parameter int                NUM_CH    = 5,
  parameter int                WIDTH     = 64,
  parameter int                DEPTH     = 2,
  parameter logic [NUM_CH-1:0] PIPE_MASK = '0,
  parameter logic [NUM_CH-1:0] FLOW_MASK = '0,
  localparam int               CW        = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enq_valid,
  output logic [NUM_CH-1:0]       enq_ready,
  input  logic [NUM_CH*WIDTH-1:0] enq_bits,
  output logic [NUM_CH-1:0]       deq_valid,
  input  logic [NUM_CH-1:0]       deq_ready,
  output logic [NUM_CH*WIDTH-1:0] deq_bits,
  input  logic [NUM_CH-1:0]       flush,
  output logic [NUM_CH*CW-1:0]    count
);

  // Pointer width; a single-entry queue still needs a 1-bit pointer.
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [PW-1:0]    enq_ptr_reg, enq_ptr_next;
      logic [PW-1:0]    deq_ptr_reg, deq_ptr_next;
      logic [CW-1:0]    cnt_reg, cnt_next;
      logic [WIDTH-1:0] enq_data;
      logic             full, empty;
      logic             enq_ok, deq_ok;
      logic             enq_fire, deq_fire;
      logic             bypass, wr_en, rd_en;

      assign enq_data = enq_bits[gi*WIDTH +: WIDTH];
      assign full     = (cnt_reg == CNT_FULL);
      assign empty    = (cnt_reg == '0);

      // Handshakes are suppressed while this channel is flushed or in reset.
      assign enq_ok = reset & ~flush[gi] &
                      (~full | (PIPE_MASK[gi] & deq_ready[gi]));
      assign deq_ok = reset & ~flush[gi] &
                      (~empty | (FLOW_MASK[gi] & enq_valid[gi]));

      assign enq_fire = enq_valid[gi] & enq_ok;
      assign deq_fire = deq_ok & deq_ready[gi];

      // A flow-mode channel that is empty hands the payload straight through;
      // storage, pointers and count are left alone in that case.
      assign bypass = FLOW_MASK[gi] & empty & enq_fire & deq_fire;
      assign wr_en  = enq_fire & ~bypass;
      assign rd_en  = deq_fire & ~bypass;

      assign enq_ready[gi]            = enq_ok;
      assign deq_valid[gi]            = deq_ok;
      assign deq_bits[gi*WIDTH +: WIDTH] = (FLOW_MASK[gi] && empty) ? enq_data
                                                                    : mem_reg[deq_ptr_reg];
      assign count[gi*CW +: CW]       = reset ? cnt_reg : '0;

      // Next-state for pointers and occupancy; flush overrides any transfer.
      always_comb begin
        enq_ptr_next = enq_ptr_reg;
        deq_ptr_next = deq_ptr_reg;
        cnt_next     = cnt_reg;
        if (wr_en) begin
          enq_ptr_next = (enq_ptr_reg == PTR_LAST) ? '0 : enq_ptr_reg + PW'(1);
        end
        if (rd_en) begin
          deq_ptr_next = (deq_ptr_reg == PTR_LAST) ? '0 : deq_ptr_reg + PW'(1);
        end
        case ({wr_en, rd_en})
          2'b10:   cnt_next = cnt_reg + CW'(1);
          2'b01:   cnt_next = cnt_reg - CW'(1);
          default: cnt_next = cnt_reg;
        endcase
        if (flush[gi]) begin
          enq_ptr_next = '0;
          deq_ptr_next = '0;
          cnt_next     = '0;
        end
      end

      // Control registers with synchronous active-low reset.
      always_ff @(posedge clock) begin
        if (!reset) begin
          enq_ptr_reg <= '0;
          deq_ptr_reg <= '0;
          cnt_reg     <= '0;
        end else begin
          enq_ptr_reg <= enq_ptr_next;
          deq_ptr_reg <= deq_ptr_next;
          cnt_reg     <= cnt_next;
        end
      end

      // Payload storage; never reset, only written on a stored enqueue.
      always_ff @(posedge clock) begin
        if (wr_en) begin
          mem_reg[enq_ptr_reg] <= enq_data;
        end
      end

`ifndef SYNTHESIS
      // Occupancy stays in range and a full queue only accepts in pipe mode.
      always_ff @(posedge clock) begin
        if (reset) begin
          assert (cnt_reg <= CNT_FULL)
            else $error("ch%0d count exceeds depth", gi);
          assert (!(enq_fire && full && !(PIPE_MASK[gi] && deq_fire)))
            else $error("ch%0d enqueue while full", gi);
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_axi4_chan_queue_bank.sv
// Bench for axi4_chan_queue_bank: two instances (DEPTH=2 with pipe/flow
// channels, DEPTH=3 plain) watched by a per-channel scoreboard queue.
module tb_axi4_chan_queue_bank;

  localparam int NCH = 5;
  localparam int W   = 8;
  localparam int CWT = 2;

  logic             clock = 1'b0;
  logic             reset;

  logic [NCH-1:0]     ev_a, er_a, dv_a, dr_a, fl_a;
  logic [NCH*W-1:0]   eb_a, db_a;
  logic [NCH*CWT-1:0] cnt_a;

  logic [NCH-1:0]     ev_b, er_b, dv_b, dr_b, fl_b;
  logic [NCH*W-1:0]   eb_b, db_b;
  logic [NCH*CWT-1:0] cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  bit stream4 = 1'b0;

  logic [W-1:0] sbq [2*NCH][$];

  always #5 clock = ~clock;

  axi4_chan_queue_bank #(
    .NUM_CH(NCH), .WIDTH(W), .DEPTH(2),
    .PIPE_MASK(5'b00001), .FLOW_MASK(5'b00010)
  ) u_dut_a (
    .clock(clock), .reset(reset),
    .enq_valid(ev_a), .enq_ready(er_a), .enq_bits(eb_a),
    .deq_valid(dv_a), .deq_ready(dr_a), .deq_bits(db_a),
    .flush(fl_a), .count(cnt_a)
  );

  axi4_chan_queue_bank #(
    .NUM_CH(NCH), .WIDTH(W), .DEPTH(3),
    .PIPE_MASK(5'b00000), .FLOW_MASK(5'b00000)
  ) u_dut_b (
    .clock(clock), .reset(reset),
    .enq_valid(ev_b), .enq_ready(er_b), .enq_bits(eb_b),
    .deq_valid(dv_b), .deq_ready(dr_b), .deq_bits(db_b),
    .flush(fl_b), .count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle monitor for one instance: checks handshake/count against the
  // scoreboard, pushes accepted payloads and pops/compares dequeued ones.
  task automatic mon(input int inst, input int depth, input logic [4:0] pm, input logic [4:0] fm,
                     input logic [4:0] ev, input logic [4:0] er, input logic [4:0] dv,
                     input logic [4:0] dr, input logic [4:0] fl, input logic [39:0] eb,
                     input logic [39:0] db, input logic [9:0] cnt);
    for (int c = 0; c < NCH; c++) begin
      int k;
      int sz;
      logic exp_dv, exp_er;
      logic [W-1:0] exp_d;
      k  = inst * NCH + c;
      sz = sbq[k].size();
      if (!reset) begin
        check_eq($sformatf("i%0d_ch%0d_rst_cnt", inst, c), 32'(cnt[c*CWT +: CWT]), 32'd0);
        check_eq($sformatf("i%0d_ch%0d_rst_dv", inst, c), 32'(dv[c]), 32'd0);
        check_eq($sformatf("i%0d_ch%0d_rst_er", inst, c), 32'(er[c]), 32'd0);
        sbq[k].delete();
      end else begin
        exp_dv = !fl[c] && (sz > 0 || (fm[c] && ev[c]));
        exp_er = !fl[c] && (sz < depth || (pm[c] && dr[c]));
        check_eq($sformatf("i%0d_ch%0d_cnt", inst, c), 32'(cnt[c*CWT +: CWT]), 32'(sz));
        check_eq($sformatf("i%0d_ch%0d_dv", inst, c), 32'(dv[c]), 32'(exp_dv));
        check_eq($sformatf("i%0d_ch%0d_er", inst, c), 32'(er[c]), 32'(exp_er));
        if (ev[c] && er[c]) sbq[k].push_back(eb[c*W +: W]);
        if (dv[c] && dr[c]) begin
          if (sbq[k].size() == 0) begin
            check_eq($sformatf("i%0d_ch%0d_underflow", inst, c), 32'd1, 32'd0);
          end else begin
            exp_d = sbq[k].pop_front();
            $display("deq inst%0d ch%0d data 0x%02h (exp 0x%02h)", inst, c, db[c*W +: W], exp_d);
            check_eq($sformatf("i%0d_ch%0d_data", inst, c), 32'(db[c*W +: W]), 32'(exp_d));
          end
        end
        if (fl[c]) sbq[k].delete();
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, 2, 5'b00001, 5'b00010, ev_a, er_a, dv_a, dr_a, fl_a, eb_a, db_a, cnt_a);
    mon(1, 3, 5'b00000, 5'b00000, ev_b, er_b, dv_b, dr_b, fl_b, eb_b, db_b, cnt_b);
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (stream4) eb_a[4*W +: W] = eb_a[4*W +: W] + 8'd1;
  endtask

  initial begin
    int v;
    int guard;
    logic fired;
    reset = 1'b0;
    ev_a = '0; dr_a = '0; fl_a = '0; eb_a = '0;
    ev_b = '0; dr_b = '0; fl_b = '0; eb_b = '0;
    repeat (3) step();
    reset = 1'b1;

    // Basic two-entry fill then drain on ch0.
    ev_a[0] = 1'b1; eb_a[0 +: W] = 8'hA1; step();
    eb_a[0 +: W] = 8'hA2; step();
    ev_a[0] = 1'b0; #1;
    check_eq("t1_count0_full", 32'(cnt_a[0 +: CWT]), 32'd2);
    check_eq("t1_enq_ready0_full", 32'(er_a[0]), 32'd0);
    dr_a[0] = 1'b1; repeat (3) step();
    dr_a[0] = 1'b0; #1;
    check_eq("t1_count0_empty", 32'(cnt_a[0 +: CWT]), 32'd0);

    // Pipe mode on ch0: full queue keeps accepting while the head leaves.
    step();
    ev_a[0] = 1'b1; eb_a[0 +: W] = 8'h10; step();
    eb_a[0 +: W] = 8'h11; step();
    for (int i = 0; i < 8; i++) begin
      dr_a[0] = 1'b1; eb_a[0 +: W] = 8'(8'h20 + i); #1;
      check_eq("pipe_enq_ready0", 32'(er_a[0]), 32'd1);
      check_eq("pipe_count0", 32'(cnt_a[0 +: CWT]), 32'd2);
      step();
    end
    ev_a[0] = 1'b0; repeat (3) step();
    dr_a[0] = 1'b0;

    // Flow mode on ch1: same-cycle bypass, then store when consumer stalls.
    ev_a[1] = 1'b1; eb_a[W +: W] = 8'h55; dr_a[1] = 1'b1; #1;
    check_eq("flow_dv1", 32'(dv_a[1]), 32'd1);
    check_eq("flow_db1", 32'(db_a[W +: W]), 32'h55);
    step();
    eb_a[W +: W] = 8'h66; dr_a[1] = 1'b0; #1;
    check_eq("flow_count1_bypass", 32'(cnt_a[2 +: CWT]), 32'd0);
    step();
    ev_a[1] = 1'b0; #1;
    check_eq("flow_count1_stored", 32'(cnt_a[2 +: CWT]), 32'd1);
    dr_a[1] = 1'b1; repeat (2) step();
    dr_a[1] = 1'b0;

    // Flush ch3 while ch4 streams continuously.
    stream4 = 1'b1; ev_a[4] = 1'b1; dr_a[4] = 1'b1; eb_a[4*W +: W] = 8'h80;
    ev_a[3] = 1'b1; eb_a[3*W +: W] = 8'h31; step();
    eb_a[3*W +: W] = 8'h32; step();
    fl_a[3] = 1'b1; eb_a[3*W +: W] = 8'h33; #1;
    check_eq("flush_enq_ready3", 32'(er_a[3]), 32'd0);
    step();
    fl_a[3] = 1'b0; ev_a[3] = 1'b0; #1;
    check_eq("flush_count3", 32'(cnt_a[6 +: CWT]), 32'd0);
    check_eq("flush_ch4_busy", 32'(dv_a[4]), 32'd1);
    dr_a[3] = 1'b1; repeat (3) step();
    dr_a[3] = 1'b0;
    stream4 = 1'b0; ev_a[4] = 1'b0; repeat (2) step();
    dr_a[4] = 1'b0;

    // Wrap on the DEPTH=3 instance: 1..10 with a toggling consumer.
    v = 1; guard = 0;
    while (v <= 10 && guard < 100) begin
      ev_b[2] = 1'b1; eb_b[2*W +: W] = 8'(v); dr_b[2] = ~guard[0]; #1;
      fired = ev_b[2] & er_b[2];
      step();
      if (fired) v++;
      guard++;
    end
    if (guard >= 100) check_eq("wrap_timeout", 32'(guard), 32'd0);
    ev_b[2] = 1'b0; dr_b[2] = 1'b1; repeat (6) step();
    dr_b[2] = 1'b0;

    // Reset in the middle of traffic drops queued entries.
    ev_a[0] = 1'b1; eb_a[0 +: W] = 8'h41; step();
    eb_a[0 +: W] = 8'h42; step();
    ev_a[0] = 1'b0; reset = 1'b0; #1;
    check_eq("rst_dv0", 32'(dv_a[0]), 32'd0);
    check_eq("rst_er0", 32'(er_a[0]), 32'd0);
    step();
    reset = 1'b1; #1;
    check_eq("rst_count0_after", 32'(cnt_a[0 +: CWT]), 32'd0);
    ev_a[0] = 1'b1; eb_a[0 +: W] = 8'h07; step();
    ev_a[0] = 1'b0; dr_a[0] = 1'b1; #1;
    check_eq("rst_first_data", 32'(db_a[0 +: W]), 32'h07);
    repeat (2) step();
    dr_a[0] = 1'b0;
    repeat (2) step();

    for (int k = 0; k < 2*NCH; k++) begin
      check_eq($sformatf("drained_q%0d", k), 32'(sbq[k].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_chan_queue_bank.md
Name: axi4_chan_queue_bank

Overview:
- Parametrised bank of NUM_CH independent ready/valid FIFOs. It is the next-generation building block for AXI4 channel buffers (AW/W/B/AR/R), replacing the per-channel fixed queues.
- Adds per-channel pipe/flow modes, occupancy counts and per-channel flush.
- Sits between a TileLink-to-AXI4 bridge and the external AXI4 port; one instance buffers any subset of channels.
- Payloads are packed, uniform width: channel i occupies bits [i*WIDTH +: WIDTH].

Parameters:
- NUM_CH, 5, number of independent channels (1..8).
- WIDTH, 64, payload bits per channel (1..256).
- DEPTH, 2, entries per channel (1..64; non-power-of-2 legal).
- PIPE_MASK, 0, bit i=1: channel i accepts enq while full if deq fires the same cycle.
- FLOW_MASK, 0, bit i=1: channel i bypasses storage combinationally when empty.
- CW, clog2(DEPTH+1), derived width of each count field; not user-set.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- enq_valid  in  NUM_CH  producer valid per channel.
- enq_ready  out  NUM_CH  bank can accept per channel.
- enq_bits  in  NUM_CH*WIDTH  packed payloads.
- deq_valid  out  NUM_CH  head entry valid.
- deq_ready  in  NUM_CH  consumer ready.
- deq_bits  out  NUM_CH*WIDTH  packed head payloads.
- flush  in  NUM_CH  discard all entries of channel i.
- count  out  NUM_CH*CW  occupancy per channel.

Behaviour:
- Per channel state: storage[DEPTH], enq_ptr, deq_ptr, cnt. full = (cnt==DEPTH); empty = (cnt==0).
- enq_fire = enq_valid&enq_ready; deq_fire = deq_valid&deq_ready.
- Reset (reset==0 at an edge): ptrs=0, cnt=0. While reset is low, outputs are forced: enq_ready=0, deq_valid=0, count=0. Storage is not cleared.
- Reset mid-transfer drops all entries; the first legal enq is in the cycle reset is 1.
- enq_ready = !full, OR'd with deq_ready when the PIPE bit is set. It is 0 during flush and reset.
- deq_valid = !empty, OR'd with enq_valid when the FLOW bit is set and empty. It is 0 during flush and reset.
- deq_bits = storage[deq_ptr]. In flow mode while empty, deq_bits = enq_bits of that channel. When deq_valid=0, deq_bits is don't-care.
- Latency, non-flow: an enq at edge N is visible as deq_valid in cycle N+1. Flow: 0 cycles.
- Flow bypass (empty, enq_fire & deq_fire): nothing is written; ptrs and cnt are unchanged.
- Write: on enq_fire (not bypassed), storage[enq_ptr]<=bits and enq_ptr advances.
- Read: on deq_fire (not bypassed), deq_ptr advances.
- Pointer wrap: ptr==DEPTH-1 -> 0.
- cnt update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Full + PIPE + deq_ready: enq accepted, cnt stays DEPTH, head advances.
- Empty, non-flow, enq+deq_ready: deq_valid=0 that cycle, so only the enq fires.
- Flush has priority over enq/deq in its cycle:
  - ptrs=0, cnt=0 at the edge; the same-cycle enq is discarded (enq_ready was 0).
  - Other channels are unaffected.
- count is registered cnt; there is no combinational path from enq/deq to count.
- Channels are fully independent; there is no shared arbitration.
- Ordering is strict FIFO per channel. Data is never duplicated or dropped except by flush or reset.
- Protocol: once deq_valid=1, payload and valid must hold until deq_fire or flush; in non-flow mode this holds by construction.
- Assertions (sim only): cnt<=DEPTH; no enq_fire when full unless PIPE & deq_fire.

Test Plan:
- Defaults; reset low 3 cycles, release; ch0 enq 0xA1,0xA2 back-to-back with deq_ready=0 -> count0=1 then 2; enq_ready0=0; then deq_ready=1 -> 0xA1, 0xA2 in order; count returns to 0.
- DEPTH=3 wrap: ch2 streams 10 values 1..10 with deq_ready toggling 1,0,1,0 -> output exactly 1..10 in order; count never >3; ptrs wrap past 2.
- PIPE_MASK=1, DEPTH=2: fill ch0, then enq_valid=deq_ready=1 for 8 cycles -> 8 enqs accepted; count0 stays 2; no bubble on enq_ready.
- FLOW_MASK=2: ch1 empty, enq 0x55 with deq_ready=1 -> deq_valid1=1, deq_bits1=0x55 same cycle, count1 stays 0. With deq_ready=0 instead -> stored, count1=1 next cycle.
- Flush: ch3 holding 2 entries, assert flush[3] with enq_valid3=1 -> count3=0 next cycle; the flushed data is never dequeued; ch4 traffic is uninterrupted.
- Reset mid-op: ch0 holds 2 entries; pull reset low 1 cycle -> deq_valid=0, enq_ready=0 during reset; after release count0=0 and a new enq 0x7 is dequeued first.
